aes_decrypt_iter: RTL and testbench
===================================

# aes_decrypt_iter

Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block, runs the initial key addition, nine full inverse rounds and the final inverse round on a single shared datapath, then presents the plaintext. It is the decrypt counterpart of the pipelined encrypt rounds. It reuses AddRoundKey and the combinational 128-bit sibling transforms InvSubBytes, InvShiftRows and InvMixColumns. Round keys come from an external key store, indexed by this block.

## Interface
- No parameters; block size 128 and Nr = 10 are fixed.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  data_in holds a ciphertext block.
- in_ready  out  1  block can accept input; high only in IDLE.
- data_in  in  128  ciphertext, same byte order as the encrypt rounds.
- key_idx  out  4  round-key index requested this cycle (0..10).
- round_key  in  128  key store output for key_idx, combinational, same cycle.
- out_valid  out  1  data_out holds plaintext.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  128  plaintext (state register).
- busy  out  1  high in ROUND or FINAL.

## Operation
- FSM states are IDLE, ROUND, FINAL and DONE. The block has one 128-bit state register, a 4-bit round counter `rnd` and the FSM register.
- IDLE:
  - Drives key_idx = 10 and in_ready = 1.
  - On in_valid: state <= data_in ^ round_key, rnd <= 9, go to ROUND.
- ROUND:
  - Drives key_idx = rnd.
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key)).
  - rnd decrements each cycle.
  - When rnd == 1, go to FINAL.
- FINAL:
  - Drives key_idx = 0.
  - state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key).
  - Go to DONE.
- DONE:
  - key_idx = 0; out_valid = 1.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; no input is queued.
- Inputs in_valid, out_ready and data_in may change arbitrarily while they are ignored.
- out_valid, in_ready, busy and key_idx are decoded from the FSM/rnd registers only; none depends combinationally on any input.

## Timing
- Reset values:
  - FSM = IDLE, state = 0, rnd = 0.
  - data_out = 0, out_valid = 0, busy = 0, in_ready = 1, key_idx = 10.
- Reset is effective immediately and asynchronously, including mid-operation. The in-flight block is discarded, and there is no partial output.
- Input handshake occurs on a rising edge with in_valid & in_ready. Call that edge E0.
- ROUND occupies E1..E9; FINAL is E10.
- out_valid rises after E10, so latency is 10 cycles from the accept edge to out_valid.
- data_out is stable for the whole time out_valid is high.
- Output handshake occurs on an edge with out_valid & out_ready, after which the block returns to IDLE.
- in_ready is high on the next cycle. There is no same-edge output-retire/input-accept overlap.
- Minimum period per block is 12 cycles with out_ready held high.
- round_key must be valid in the same cycle key_idx is driven. The key store adds no latency.

## Configuration
- Macro: `AES_DEC_ZEROIZE_EN`.
- Defined:
  - On the output-handshake edge, state is cleared to 0, so data_out reads 0 in IDLE.
  - Plaintext never persists after it has been consumed.
- Undefined:
  - state is untouched on the output handshake.
  - data_out keeps the last plaintext until the next accept edge.
- Handshake timing is identical in both builds.

## Test plan
- FIPS-197 C.1 decrypt:
  - Bench key store is expanded from key 000102030405060708090a0b0c0d0e0f, with rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Stimulus: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: data_out = 00112233445566778899aabbccddeeff, with out_valid exactly 10 cycles after accept.
- key_idx sequence:
  - Monitor key_idx from E0 through DONE.
  - Required sequence: 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0.
  - busy is high for exactly 10 cycles.
- Output backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid.
  - Required: out_valid and data_out stay stable, in_ready stays 0, and a toggling in_valid is ignored.
  - Release out_ready: the next cycle shows in_ready = 1.
- Back-to-back blocks:
  - Stimulus: two FIPS-197 vectors with out_ready tied high.
  - Required: both plaintexts are correct and accepts are spaced 12 cycles apart.
- Reset mid-operation:
  - Deassert rst_n at E5, asynchronously between edges.
  - Required: out_valid = 0, data_out = 0, in_ready = 1 and key_idx = 10 immediately.
  - After release, a fresh vector decrypts correctly.
- Zeroize:
  - With `AES_DEC_ZEROIZE_EN`, data_out = 0 on the cycle after the output handshake.
  - Without it, data_out still holds 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter
//
// Iterative AES-128 inverse cipher. One ciphertext block is accepted in IDLE.
// On the accept edge the initial AddRoundKey with round key 10 is applied.
// Nine full inverse rounds follow, then the final inverse round, which has no
// InvMixColumns. All rounds use one shared datapath and one 128-bit state
// register. The plaintext is then held in DONE until the consumer takes it.
// Round keys come from an external key store that answers combinationally
// in the same cycle as key_idx.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   data_in carries a ciphertext block (sampled in IDLE only)
//   in_ready   high in IDLE
//   data_in    128-bit ciphertext, byte 0 in bits [127:120]
//   key_idx    round-key index requested this cycle (10 .. 0)
//   round_key  key store output for key_idx, same cycle
//   out_valid  data_out holds plaintext (DONE)
//   out_ready  consumer accepts data_out
//   data_out   plaintext, driven straight from the state register
//   busy       high in ROUND or FINAL
//
// Build option
//   AES_DEC_ZEROIZE_EN : when defined, the state register is cleared on the
//   output handshake edge so that plaintext does not linger after it has been
//   consumed. Handshake timing does not change.
// ---------------------------------------------------------------------------
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [127:0] state;
  logic [127:0] core;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte b of the state is row (b % 4), column (b / 4), located at
  // bits [127-8b -: 8]; this matches the encrypt rounds.

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      o[127-8*b -: 8] = INV_SBOX[s[127-8*b -: 8]];
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns. The constants 09/0b/0d/0e are built from
  // the x2, x4 and x8 multiples, so only three xtime stages are needed.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = w[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[i] = x8 ^ a[i];
      m0b[i] = x8 ^ x2 ^ a[i];
      m0d[i] = x8 ^ x4 ^ a[i];
      m0e[i] = x8 ^ x4 ^ x2;
    end
    return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
            m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
            m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
            m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Shared round core: InvShiftRows -> InvSubBytes -> AddRoundKey.
  // ROUND adds InvMixColumns on top of this; FINAL stores it directly.
  always_comb begin
    core = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
  end

  // ---- state / control register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      rnd   <= 4'd0;
      state <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state <= data_in ^ round_key;
            rnd   <= 4'd9;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          state <= inv_mix_columns(core);
          rnd   <= rnd - 4'd1;
          if (rnd == 4'd1) begin
            fsm <= FINAL;
          end
        end
        FINAL: begin
          state <= core;
          fsm   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            fsm <= IDLE;
`ifdef AES_DEC_ZEROIZE_EN
            state <= '0;
`else
            state <= state;
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Status and key index are decoded only from registers, so nothing here
  // has a combinational path from an input.
  always_comb begin
    key_idx = 4'd0;
    case (fsm)
      IDLE:    key_idx = 4'd10;
      ROUND:   key_idx = rnd;
      FINAL:   key_idx = 4'd0;
      DONE:    key_idx = 4'd0;
      default: key_idx = 4'd0;
    endcase
  end

  assign in_ready  = (fsm == IDLE);
  assign busy      = (fsm == ROUND) || (fsm == FINAL);
  assign out_valid = (fsm == DONE);
  assign data_out  = state;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iter
//
// Bench for the iterative AES-128 inverse cipher. The reference model is a
// forward AES-128 cipher. Its S-box is derived from GF(2^8) inversion and
// the affine map. Random plaintexts are encrypted by the model, the
// ciphertexts are fed to the DUT, and the DUT must return the original
// plaintext. The bench also acts as the combinational round-key store.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [11];

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`ifdef AES_DEC_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    round_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;
  end

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tmp[4*c+row] = st[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (r < 10) begin
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a sample point (1 time unit after a rising edge) with the DUT
  // in IDLE. Returns with the DUT in DONE, at a sample point.
  task automatic run_one(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt);
    int lat;
    int busy_cnt;
    chk({tag, "_pre_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_key_e0"}, 128'(key_idx), 128'(10));
    in_valid = 1'b1;
    data_in  = ct;
    @(posedge clk); #1;
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 10) chk({tag, "_key_seq"}, 128'(key_idx), 128'(9 - lat));
      if (busy) busy_cnt++;
      chk({tag, "_in_ready_busy"}, 128'(in_ready), 128'(0));
      in_valid = 1'($urandom);
      data_in  = rand128();
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'(10));
    chk({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(10));
    chk({tag, "_data_out"}, data_out, exp_pt);
    chk({tag, "_key_done"}, 128'(key_idx), 128'(0));
    chk({tag, "_busy_done"}, 128'(busy), 128'(0));
  endtask

  task automatic retire(input string tag, input logic [127:0] exp_pt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ret_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_ret_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_ret_data_out"}, data_out, ZEROIZE ? 128'h0 : exp_pt);
  endtask

  initial begin
    logic [127:0] pt, pt2, ct, ct2, key;
    logic [127:0] got [2];
    int           acc_t [2];
    int           accepts, rets, guard;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;

    build_sbox();
    expand_key(FIPS_KEY);
    chk("model_rk10", rk[10], FIPS_RK10);
    chk("model_fips_enc", aes_encrypt(FIPS_PT), FIPS_CT);

    // Reset state
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_key_idx", 128'(key_idx), 128'(10));
    chk("rst_data_out", data_out, 128'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1 decrypt
    run_one("fips", FIPS_CT, FIPS_PT);
    retire("fips", FIPS_PT);

    // Output backpressure with a toggling, ignored in_valid
    @(posedge clk); #1;
    pt = rand128();
    ct = aes_encrypt(pt);
    run_one("bp", ct, pt);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      data_in  = rand128();
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_data_out", data_out, pt);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    retire("bp", pt);

    // Random plaintexts with the FIPS key
    for (int n = 0; n < 4; n++) begin
      pt = rand128();
      ct = aes_encrypt(pt);
      run_one("rand", ct, pt);
      retire("rand", pt);
    end

    // Random key
    key = rand128();
    expand_key(key);
    for (int n = 0; n < 2; n++) begin
      pt = rand128();
      ct = aes_encrypt(pt);
      run_one("rkey", ct, pt);
      retire("rkey", pt);
    end
    expand_key(FIPS_KEY);

    // Back-to-back blocks, out_ready tied high
    pt  = FIPS_PT;
    ct  = FIPS_CT;
    pt2 = rand128();
    ct2 = aes_encrypt(pt2);
    got[0] = '0; got[1] = '0;
    acc_t[0] = 0; acc_t[1] = 0;
    accepts = 0; rets = 0; guard = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = ct;
    while (rets < 2 && guard < 60) begin
      if (in_ready && in_valid && accepts < 2) begin
        acc_t[accepts] = cyc;
        accepts++;
      end
      if (out_valid) begin
        got[rets] = data_out;
        rets++;
      end
      @(posedge clk); #1;
      guard++;
      if (accepts == 1) data_in = ct2;
      if (accepts == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 128'(accepts), 128'(2));
    chk("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'(12));
    chk("b2b_pt0", got[0], pt);
    chk("b2b_pt1", got[1], pt2);
    chk("b2b_idle", 128'(in_ready), 128'(1));

    // Reset mid-operation, asserted between edges after E5
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in  = FIPS_CT;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data_out", data_out, 128'h0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_key_idx", 128'(key_idx), 128'(10));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));
    pt = rand128();
    ct = aes_encrypt(pt);
    run_one("post_rst", ct, pt);
    retire("post_rst", pt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
